// File: rtl/des_key_schedule.sv
// Sequential DES round-key source: PC-1 on the loaded key, then one C/D rotation per accepted round.
// Optional right-rotation (decrypt) schedule is built only when DES_KEY_SCHED_DECRYPT_EN is defined.
module des_key_schedule #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [0:63] key_in,
  input  logic        cd_ready,
  output logic        cd_valid,
  output logic [0:55] cd_out,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  // FIPS 46-3 PC-1 with entries minus 1; index 0 is the key MSB.
  localparam int unsigned PC1_TAB [0:55] = '{
    56, 48, 40, 32, 24, 16,  8,  0, 57, 49, 41, 33, 25, 17,
     9,  1, 58, 50, 42, 34, 26, 18, 10,  2, 59, 51, 43, 35,
    62, 54, 46, 38, 30, 22, 14,  6, 61, 53, 45, 37, 29, 21,
    13,  5, 60, 52, 44, 36, 28, 20, 12,  4, 27, 19, 11,  3
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_reg;
  logic [0:27] c_reg;
  logic [0:27] d_reg;
  logic [0:55] pc1_cd;
  logic [7:0]  unused_parity;

  genvar gi;
  generate
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1_cd[gi] = key_in[PC1_TAB[gi]];
    end
    for (gi = 0; gi < 8; gi++) begin : g_parity
      assign unused_parity[gi] = key_in[8*gi + 7];
    end
  endgenerate

  // Rounds 1, 2, 9 and 16 shift by one; the decrypt schedule starts from C16D16 = C0D0.
  function automatic logic [1:0] shift_amt(input logic [3:0] r, input logic dec);
    if (dec && (r == 4'd0))
      return 2'd0;
    if ((r == 4'd0) || (r == 4'd1) || (r == 4'd8) || (r == 4'd15))
      return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [0:27] rotl28(input logic [0:27] x, input logic [1:0] amt);
    logic [0:27] y;
    y = x;
    if (amt == 2'd1)
      y = {x[1:27], x[0]};
    else if (amt == 2'd2)
      y = {x[2:27], x[0:1]};
    return y;
  endfunction

  logic [3:0]  next_idx;
  logic        last_round;
  logic [0:27] load_c;
  logic [0:27] load_d;
  logic [0:27] step_c;
  logic [0:27] step_d;

  assign next_idx   = round_idx + 4'd1;
  assign last_round = (round_idx == 4'(ROUNDS - 1));

`ifdef DES_KEY_SCHED_DECRYPT_EN
  logic dec_reg;

  function automatic logic [0:27] rotr28(input logic [0:27] x, input logic [1:0] amt);
    logic [0:27] y;
    y = x;
    if (amt == 2'd1)
      y = {x[27], x[0:26]};
    else if (amt == 2'd2)
      y = {x[26:27], x[0:25]};
    return y;
  endfunction

  always_comb begin
    load_c = '0;
    load_d = '0;
    step_c = '0;
    step_d = '0;
    if (decrypt) begin
      load_c = rotr28(pc1_cd[0:27], shift_amt(4'd0, 1'b1));
      load_d = rotr28(pc1_cd[28:55], shift_amt(4'd0, 1'b1));
    end else begin
      load_c = rotl28(pc1_cd[0:27], shift_amt(4'd0, 1'b0));
      load_d = rotl28(pc1_cd[28:55], shift_amt(4'd0, 1'b0));
    end
    if (dec_reg) begin
      step_c = rotr28(c_reg, shift_amt(next_idx, 1'b1));
      step_d = rotr28(d_reg, shift_amt(next_idx, 1'b1));
    end else begin
      step_c = rotl28(c_reg, shift_amt(next_idx, 1'b0));
      step_d = rotl28(d_reg, shift_amt(next_idx, 1'b0));
    end
  end
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt;

  always_comb begin
    load_c = rotl28(pc1_cd[0:27], shift_amt(4'd0, 1'b0));
    load_d = rotl28(pc1_cd[28:55], shift_amt(4'd0, 1'b0));
    step_c = rotl28(c_reg, shift_amt(next_idx, 1'b0));
    step_d = rotl28(d_reg, shift_amt(next_idx, 1'b0));
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      c_reg     <= '0;
      d_reg     <= '0;
      round_idx <= '0;
      cd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DES_KEY_SCHED_DECRYPT_EN
      dec_reg   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            c_reg     <= load_c;
            d_reg     <= load_d;
            round_idx <= 4'd0;
            cd_valid  <= 1'b1;
            busy      <= 1'b1;
`ifdef DES_KEY_SCHED_DECRYPT_EN
            dec_reg   <= decrypt;
`endif
          end
        end
        RUN: begin
          if (cd_valid && cd_ready) begin
            if (last_round) begin
              // cd_out and round_idx keep the final round's value.
              state_reg <= IDLE;
              cd_valid  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              c_reg     <= step_c;
              d_reg     <= step_d;
              round_idx <= next_idx;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cd_out = {c_reg, d_reg};

endmodule
